// File: rtl/fnd_scan_ctrl_if.sv
// Interface bundling the value handshake, display controls and FND pin outputs
// of the scan controller.
interface fnd_scan_ctrl_if #(
  parameter int NUM_DIGITS = 4,
  parameter int BIN_W      = 14
);
  logic [BIN_W-1:0]      bin_in;
  logic                  bin_valid;
  logic                  bin_ready;
  logic                  lz_blank;
  logic [NUM_DIGITS-1:0] dp_in;
  logic                  blink_en;
  logic [NUM_DIGITS-1:0] fnd_com;
  logic [7:0]            fnd_data;
  logic                  ovf;

  // Upstream datapath side: supplies the value and display controls.
  modport master (
    output bin_in, bin_valid, lz_blank, dp_in, blink_en,
    input  bin_ready, fnd_com, fnd_data, ovf
  );

  // Controller side.
  modport slave (
    input  bin_in, bin_valid, lz_blank, dp_in, blink_en,
    output bin_ready, fnd_com, fnd_data, ovf
  );
endinterface

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller. A binary value taken over
// a valid/ready handshake is converted to BCD by a bit-serial double-dabble
// engine, committed atomically to the display register, then scanned one digit
// per slot with leading-zero blanking, decimal points, blink and overflow.
module fnd_scan_ctrl #(
  parameter int NUM_DIGITS  = 4,
  parameter int BIN_W       = 14,
  parameter int SCAN_DIV    = 100_000,
  parameter int BLINK_TICKS = 250
) (
  input logic             clk,
  input logic             rst,
  fnd_scan_ctrl_if.slave  bus
);

  localparam int DIV_W  = $clog2(SCAN_DIV);
  localparam int BLK_W  = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam int SEL_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int STEP_W = $clog2(BIN_W + 1);
  localparam int BCD_W  = 4 * (NUM_DIGITS + 1);
  localparam int DISP_W = 4 * NUM_DIGITS;

  function automatic logic [31:0] pow10(input int n);
    logic [31:0] p;
    p = 32'd1;
    for (int i = 0; i < n; i++) p = p * 32'd10;
    return p;
  endfunction

  localparam logic [31:0] OVF_LIMIT = pow10(NUM_DIGITS);

  // Active-low segment pattern {dp,g,f,e,d,c,b,a}; dp is left dark here.
  function automatic logic [7:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'd0:    return 8'hC0;
      4'd1:    return 8'hF9;
      4'd2:    return 8'hA4;
      4'd3:    return 8'hB0;
      4'd4:    return 8'h99;
      4'd5:    return 8'h92;
      4'd6:    return 8'h82;
      4'd7:    return 8'hF8;
      4'd8:    return 8'h80;
      4'd9:    return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_COMMIT} state_t;

  state_t              state, state_nxt;
  logic                accept, step_last;
  logic [BIN_W-1:0]    bin_sr;
  logic [BCD_W-1:0]    bcd_sr, bcd_adj;
  logic [STEP_W-1:0]   step_cnt;
  logic                cmp_ovf;
  logic [DISP_W-1:0]   disp_bcd;

  logic [DIV_W-1:0]    div_cnt;
  logic                tick;
  logic [SEL_W-1:0]    sel;
  logic [BLK_W-1:0]    blink_cnt;
  logic                blink_on;

  logic [3:0]          cur_nib;
  logic                cur_dp, lead_zero, zero_run;
  logic [7:0]          seg_nxt;
  logic [NUM_DIGITS-1:0] com_nxt;

  assign bus.bin_ready = (state == S_IDLE);
  assign accept        = bus.bin_valid && bus.bin_ready;
  assign step_last     = (step_cnt == STEP_W'(BIN_W - 1));
  assign tick          = (div_cnt == DIV_W'(SCAN_DIV - 1));

  // Conversion FSM state register.
  // NOTE: clocked state uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // Conversion FSM next state: one SHIFT edge per input bit, then one COMMIT.
  // NOTE: defaults come first so no path leaves a combinational output
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (accept)    state_nxt = S_SHIFT;
      S_SHIFT:  if (step_last) state_nxt = S_COMMIT;
      S_COMMIT:                state_nxt = S_IDLE;
      default:                 state_nxt = S_IDLE;
    endcase
  end

  // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
  always_comb begin
    bcd_adj = bcd_sr;
    for (int i = 0; i < NUM_DIGITS + 1; i++) begin
      if (bcd_sr[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
    end
  end

  // Conversion datapath: capture, shift, and atomic commit to the display.
  // NOTE: the display register and ovf are reset so the panel shows a clean 0
  // after reset; the shift registers are reset only for deterministic state.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_sr   <= '0;
      bcd_sr   <= '0;
      step_cnt <= '0;
      cmp_ovf  <= 1'b0;
      disp_bcd <= '0;
      bus.ovf  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            bin_sr   <= bus.bin_in;
            bcd_sr   <= '0;
            step_cnt <= '0;
            cmp_ovf  <= (32'(bus.bin_in) >= OVF_LIMIT);
          end
        end
        S_SHIFT: begin
          bin_sr   <= bin_sr << 1;
          bcd_sr   <= (bcd_adj << 1) | BCD_W'(bin_sr[BIN_W-1]);
          step_cnt <= step_cnt + STEP_W'(1);
        end
        S_COMMIT: begin
          disp_bcd <= cmp_ovf ? {NUM_DIGITS{4'd9}} : bcd_sr[DISP_W-1:0];
          bus.ovf  <= cmp_ovf;
        end
        default: ;
      endcase
    end
  end

  // Scan divider and digit select: one digit slot per SCAN_DIV cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      sel     <= '0;
    end else begin
      div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
      if (tick) sel <= (sel == SEL_W'(NUM_DIGITS - 1)) ? '0 : sel + SEL_W'(1);
    end
  end

  // Blink timer: counts scan ticks while enabled, toggles phase every BLINK_TICKS.
  always_ff @(posedge clk) begin
    if (rst || !bus.blink_en) begin
      blink_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (tick) begin
      if (blink_cnt == BLK_W'(BLINK_TICKS - 1)) begin
        blink_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        blink_cnt <= blink_cnt + BLK_W'(1);
      end
    end
  end

  // Selected-digit pattern: walk from the top digit down so zero_run tells
  // whether the selected digit and everything above it are zero.
  always_comb begin
    cur_nib   = '0;
    cur_dp    = 1'b0;
    lead_zero = 1'b0;
    zero_run  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run && (disp_bcd[4*k +: 4] == 4'd0);
      if (sel == SEL_W'(k)) begin
        cur_nib   = disp_bcd[4*k +: 4];
        cur_dp    = bus.dp_in[k];
        lead_zero = zero_run;
      end
    end
    if (bus.lz_blank && !bus.ovf && (sel != '0) && lead_zero) seg_nxt = 8'hFF;
    else                                                      seg_nxt = seg_decode(cur_nib);
    if (cur_dp) seg_nxt[7] = 1'b0;
    com_nxt = ~(NUM_DIGITS'(1) << sel);
  end

  // Registered pin drivers; the OFF blink phase darkens everything.
  always_ff @(posedge clk) begin
    if (rst || !blink_on) begin
      bus.fnd_com  <= '1;
      bus.fnd_data <= 8'hFF;
    end else begin
      bus.fnd_com  <= com_nxt;
      bus.fnd_data <= seg_nxt;
    end
  end

endmodule
